// File: rtl/ps2_keyboard_axi_fifo.sv
// PS/2 keyboard peripheral on AXI4-Lite: filtered PS/2 receiver, scan-code
// decoder, key-event FIFO, live game-key bitmap and a level interrupt.
//
// Decoder FSM
//   state      | meaning
//   ST_IDLE    | no prefix seen
//   ST_EXT     | E0 prefix seen
//   ST_BRK     | F0 prefix seen
//   ST_EXT_BRK | E0 and F0 prefixes seen
`timescale 1ns/1ps
module ps2_keyboard_axi_fifo #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 16,
    parameter int FILTER_CYCLES      = 8,
    parameter int TIMEOUT_CYCLES     = 100000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic                            irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;

    logic             clk_meta, clk_sync, data_meta, data_sync, clk_filt, fall;
    logic [FLT_W-1:0] filt_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame_bits;
    logic [TMO_W-1:0] tmo_cnt;
    logic             rx_valid, frame_err;
    logic [7:0]       rx_byte;
    dec_state_t       state_q, state_d;
    logic             push_ev, ev_ext, ev_brk, key_hit;
    logic [2:0]       key_idx;
    logic [9:0]       ev_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       count_byte, keys;
    logic             fifo_empty, fifo_full, do_push, pop, ovf_set;
    logic             ie, ovf, perr;
    logic             aw_ready, b_valid, ar_ready, r_valid;
    logic [31:0]      r_data, rd_mux;
    logic             wr_hs, rd_hs, wr_ctrl, flush, clr_err;
    logic             unused_bits;

    // Synchronise both PS/2 lines and accept a clock level only once it is stable
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_filt  <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            fall      <= 1'b0;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
                clk_filt <= clk_sync;
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Shift in frame bits LSB-first, validate the frame, abort stale partial frames
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bit_cnt    <= '0;
            frame_bits <= '0;
            tmo_cnt    <= '0;
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!frame_bits[0] && data_sync && (^frame_bits[9:1])) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= frame_bits[8:1];
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    frame_bits <= {data_sync, frame_bits[9:1]};
                    bit_cnt    <= bit_cnt + 1'b1;
                end
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
                if (tmo_cnt == TMO_W'(1)) bit_cnt <= '0;
            end
        end
    end

    // Decoder state register
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Decoder next state and event emission
    always_comb begin
        state_d = state_q;
        push_ev = 1'b0;
        ev_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        ev_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        if (rx_valid) begin
            if (rx_byte == 8'hE0) begin
                if (state_q == ST_IDLE)     state_d = ST_EXT;
                else if (state_q == ST_BRK) state_d = ST_EXT_BRK;
            end else if (rx_byte == 8'hF0) begin
                if (state_q == ST_IDLE)     state_d = ST_BRK;
                else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
            end else begin
                push_ev = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // Map decoded codes onto the eight game-key bitmap positions
    always_comb begin
        key_hit = 1'b0;
        key_idx = 3'd0;
        case ({ev_ext, rx_byte})
            9'h16B: begin key_hit = 1'b1; key_idx = 3'd0; end
            9'h174: begin key_hit = 1'b1; key_idx = 3'd1; end
            9'h175: begin key_hit = 1'b1; key_idx = 3'd2; end
            9'h172: begin key_hit = 1'b1; key_idx = 3'd3; end
            9'h029: begin key_hit = 1'b1; key_idx = 3'd4; end
            9'h05A: begin key_hit = 1'b1; key_idx = 3'd5; end
            9'h076: begin key_hit = 1'b1; key_idx = 3'd6; end
            9'h04D: begin key_hit = 1'b1; key_idx = 3'd7; end
            default: ;
        endcase
    end

    assign wr_hs      = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs      = ar_ready && S_AXI_ARVALID;
    assign wr_ctrl    = wr_hs && (S_AXI_AWADDR[3:2] == 2'b11) && S_AXI_WSTRB[0];
    assign flush      = wr_ctrl && S_AXI_WDATA[2];
    assign clr_err    = wr_ctrl && S_AXI_WDATA[1];
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop        = rd_hs && (S_AXI_ARADDR[3:2] == 2'b01) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push    = push_ev && !flush && (!fifo_full || pop);
    assign ovf_set    = push_ev && !flush && fifo_full && !pop;
    assign count_byte = 8'(fifo_count);
    assign irq        = ie && !fifo_empty;

    // Event storage, kept reset-free so it can map to distributed RAM
    always_ff @(posedge ACLK) begin
        if (do_push) ev_mem[wr_ptr] <= {ev_ext, ev_brk, rx_byte};
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge ACLK) begin
        if (ARESET || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !do_push) fifo_count <= fifo_count - 1'b1;
        end
    end

    // Control/status bits and key bitmap; a new error wins over a same-cycle clear
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ie   <= 1'b0;
            ovf  <= 1'b0;
            perr <= 1'b0;
            keys <= '0;
        end else begin
            if (wr_ctrl)        ie   <= S_AXI_WDATA[0];
            if (ovf_set)        ovf  <= 1'b1;
            else if (clr_err)   ovf  <= 1'b0;
            if (frame_err)      perr <= 1'b1;
            else if (clr_err)   perr <= 1'b0;
            if (push_ev && key_hit) keys[key_idx] <= !ev_brk;
        end
    end

    // Read data selection
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            2'b00: rd_mux = {16'h0, count_byte, 5'b0, perr, ovf, fifo_empty};
            2'b01: rd_mux = fifo_empty ? 32'h0 : {1'b1, 21'b0, ev_mem[rd_ptr]};
            2'b10: rd_mux = {24'h0, keys};
            default: rd_mux = {31'h0, ie};
        endcase
    end

    // AXI4-Lite handshakes: single-cycle READY pulses, VALID held until accepted
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready <= 1'b0;
            b_valid  <= 1'b0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            aw_ready <= S_AXI_AWVALID && S_AXI_WVALID && !aw_ready && !b_valid;
            if (wr_hs)             b_valid <= 1'b1;
            else if (S_AXI_BREADY) b_valid <= 1'b0;
            ar_ready <= S_AXI_ARVALID && !ar_ready && !r_valid;
            if (rd_hs) begin
                r_valid <= 1'b1;
                r_data  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = aw_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = 2'b00;
    assign unused_bits   = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};
endmodule

// File: tb/tb_ps2_keyboard_axi_fifo.sv
// Scoreboarded bench for ps2_keyboard_axi_fifo: PS/2 frames and AXI accesses
// are driven from one process, expected read data is queued from a
// behavioural keyboard model, and a monitor compares every returned read.
`timescale 1ns/1ps
module tb_ps2_keyboard_axi_fifo;
    localparam int DEPTH = 8;
    localparam int TMO   = 1000;
    localparam int HALF  = 20;

    logic        ACLK = 1'b0, ARESET = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, irq;
    logic [3:0]  AWADDR = '0, ARADDR = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1, ARVALID = 1'b0, RREADY = 1'b1;
    logic [31:0] WDATA = '0, RDATA;
    logic [3:0]  WSTRB = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;

    ps2_keyboard_axi_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_CYCLES(8), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .irq(irq),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY));

    always #5 ACLK = ~ACLK;

    int n_vec = 0, n_bad = 0;
    int unsigned exp_q[$];
    string       name_q[$];
    int unsigned mon_exp;
    string       mon_name;

    // keyboard model
    int unsigned m_fifo[$];
    logic [7:0]  m_keys = '0;
    bit          m_ie, m_ovf, m_perr, m_ext, m_brk;

    always @(negedge ACLK) begin
        if (RVALID && RREADY) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read got=%h", RDATA);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (RDATA !== mon_exp || RRESP !== 2'b00) begin
                    n_bad++;
                    $display("FAIL %s got=%h resp=%0d want=%h resp=0", mon_name, RDATA, RRESP, mon_exp);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int unsigned got, input int unsigned want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic int key_index(input bit ext, input logic [7:0] c);
        if (ext) begin
            case (c)
                8'h6B: return 0;
                8'h74: return 1;
                8'h75: return 2;
                8'h72: return 3;
                default: return -1;
            endcase
        end
        case (c)
            8'h29: return 4;
            8'h5A: return 5;
            8'h76: return 6;
            8'h4D: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({22'h0, m_ext, m_brk, b});
            else                       m_ovf = 1'b1;
            k = key_index(m_ext, b);
            if (k >= 0) m_keys[k] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_keys = '0; m_ie = 0; m_ovf = 0; m_perr = 0; m_ext = 0; m_brk = 0;
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            repeat (HALF) @(posedge ACLK);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge ACLK);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        send_bits({1'b1, par, b, 1'b0}, 11);
        repeat (HALF) @(posedge ACLK);
        if (bad_par) m_perr = 1'b1;
        else         model_byte(b);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int unsigned want, input string nm);
        int k;
        exp_q.push_back(want);
        name_q.push_back(nm);
        @(negedge ACLK);
        ARADDR = addr; ARVALID = 1'b1;
        k = 0;
        while (!ARREADY && k < 50) begin @(negedge ACLK); k++; end
        if (!ARREADY) begin
            n_vec++; n_bad++;
            $display("FAIL %s arready_timeout got=0 want=1", nm);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] strb);
        int k;
        @(negedge ACLK);
        AWADDR = addr; WDATA = d; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
        k = 0;
        while (!AWREADY && k < 50) begin @(negedge ACLK); k++; end
        check("awready_wready", {AWREADY, WREADY}, 2'b11);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        check("bvalid_bresp", {BVALID, BRESP}, 3'b100);
        @(negedge ACLK);
        if (addr == 4'hC && strb[0]) begin
            m_ie = d[0];
            if (d[1]) begin m_ovf = 0; m_perr = 0; end
            if (d[2]) m_fifo.delete();
        end
    endtask

    task automatic read_data();
        int unsigned w;
        w = (m_fifo.size() != 0) ? (32'h8000_0000 | m_fifo.pop_front()) : 32'h0;
        axi_read(4'h4, w, "data");
    endtask

    task automatic read_status();
        axi_read(4'h0, (m_fifo.size() << 8) | (int'(m_perr) << 2) | (int'(m_ovf) << 1)
                       | int'(m_fifo.size() == 0), "status");
    endtask

    task automatic read_keys();
        axi_read(4'h8, {24'h0, m_keys}, "keys");
    endtask

    task automatic check_irq(input string nm);
        @(negedge ACLK);
        check(nm, irq, (m_ie && m_fifo.size() != 0) ? 1 : 0);
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72,
                             8'h29, 8'h5A, 8'h76, 8'h4D, 8'h1C, 8'h15};

    initial begin
        model_reset();
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_outputs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, irq}, 0);
        check("reset_rdata", RDATA, 0);
        ARESET = 1'b0;
        read_status();
        read_keys();
        read_data();
        axi_read(4'hC, 0, "ctrl_reset");

        // single make code with interrupt
        axi_write(4'hC, 32'h1, 4'hF);
        send_byte(8'h1C, 0);
        check_irq("irq_after_push");
        read_data();
        read_status();
        check_irq("irq_after_pop");

        // extended make then extended break
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        read_keys();
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
        read_data(); read_data();
        read_keys();

        // overflow
        for (int i = 0; i < DEPTH + 2; i++) send_byte(8'($urandom_range(8'h01, 8'hDF)), 0);
        read_status();
        for (int i = 0; i < DEPTH; i++) read_data();
        axi_write(4'hC, 32'h3, 4'hF);
        read_status();

        // parity error, then recovery
        send_byte(8'h33, 1);
        read_status();
        check_irq("irq_no_event_on_perr");
        send_byte(8'h29, 0);
        read_keys();
        read_data();
        axi_write(4'hC, 32'h3, 4'hF);

        // partial frame aborted by timeout
        send_bits({1'b1, ~(^8'h5A), 8'h5A, 1'b0}, 6);
        repeat (TMO + 200) @(posedge ACLK);
        send_byte(8'h5A, 0);
        read_status();
        read_data();
        read_status();

        // byte strobe and read-only writes
        axi_write(4'hC, 32'h0, 4'h0);
        axi_read(4'hC, {31'h0, m_ie}, "ctrl_wstrb");
        axi_write(4'h8, 32'hFF, 4'hF);
        read_keys();

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: send_byte(pool[$urandom_range(0, 11)], ($urandom_range(0, 11) == 0));
                6: read_data();
                7: read_status();
                8: read_keys();
                default: axi_write(4'hC, {29'h0, 1'($urandom_range(0, 1)),
                                          1'($urandom_range(0, 1)), 1'b1}, 4'h1);
            endcase
            check_irq("irq_random");
        end
        while (m_fifo.size() != 0) read_data();
        read_status();

        // reset in the middle of a frame with events queued
        axi_write(4'hC, 32'h7, 4'hF);
        send_byte(8'h1C, 0); send_byte(8'h29, 0);
        send_bits({1'b1, ~(^8'h5A), 8'h5A, 1'b0}, 5);
        check_irq("irq_before_reset");
        @(negedge ACLK); ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        model_reset();
        check_irq("irq_after_reset");
        read_status();
        read_keys();
        send_byte(8'h1C, 0);
        read_data();

        repeat (5) @(negedge ACLK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
